i2s_fifo_sched: RTL

Transfer scheduler between the APB register interface and the I2S Tx/Rx FIFOs, in the `pclk` domain. It owns the Tx holding-register and Rx holding-register occupancy. It arbitrates one FIFO access per slot between Tx pushes and Rx pops using round-robin. It also tracks stereo channel order and reports APB protocol misuse.

---
 rtl/i2s_fifo_sched_if.sv | 28 ++
 rtl/i2s_fifo_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/i2s_fifo_sched_if.sv
// APB-side handshake bundle for the I2S FIFO scheduler.
// Master drives the access strobes; the scheduler returns pulses.
interface i2s_fifo_sched_if;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic        reg_wen;
  logic        reg_ren;
  logic        apb_err;

  modport master (
    output penable,
    output pwrite,
    output paddr,
    input  reg_wen,
    input  reg_ren,
    input  apb_err
  );

  modport slave (
    input  penable,
    input  pwrite,
    input  paddr,
    output reg_wen,
    output reg_ren,
    output apb_err
  );
endinterface

// File: rtl/i2s_fifo_sched.sv
// Tx/Rx holding-register scheduler with round-robin FIFO arbitration.
// Define I2S_SCHED_STATS_EN to build the saturating error counters.
module i2s_fifo_sched #(
  parameter logic [31:0] TX_ADDR = 32'h0,
  parameter logic [31:0] RX_ADDR = 32'h8,
  parameter int          CNT_W   = 8
) (
  input  logic             pclk,
  input  logic             preset,
  i2s_fifo_sched_if.slave  apb,
  input  logic             stop,
  input  logic             stereo,
  input  logic             tx_full,
  input  logic             rx_empty,
  output logic             tx_wen,
  output logic             rx_ren,
  output logic             tx_pend,
  output logic             rx_valid,
  output logic             tx_chan,
  output logic             rx_chan,
  output logic             busy,
  output logic [CNT_W-1:0] tx_drop_cnt,
  output logic [CNT_W-1:0] rx_under_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    TX_PUSH,
    RX_POP,
    SETTLE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_rx;
  logic rx_seq;
  logic pop_chan;

  logic tx_hit;
  logic rx_hit;
  logic tx_acc;
  logic tx_rej;
  logic rx_acc;
  logic rx_rej;
  logic req_tx;
  logic req_rx;

  assign tx_hit = apb.penable & apb.pwrite
                & (apb.paddr == TX_ADDR);
  assign rx_hit = apb.penable & ~apb.pwrite
                & (apb.paddr == RX_ADDR);

  assign tx_acc = tx_hit & ~tx_pend;
  assign tx_rej = tx_hit & tx_pend;
  assign rx_acc = rx_hit & rx_valid;
  assign rx_rej = rx_hit & ~rx_valid;

  assign req_tx = tx_pend & ~tx_full & ~stop;
  assign req_rx = ~rx_valid & ~rx_empty & ~stop;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_tx && (!req_rx || last_rx))
          state_nxt = TX_PUSH;
        else if (req_rx)
          state_nxt = RX_POP;
      end
      TX_PUSH: state_nxt = SETTLE;
      RX_POP:  state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Strobes are loaded from the next state so they line up with it.
  always_ff @(posedge pclk) begin
    if (preset) begin
      apb.reg_wen <= 1'b0;
      apb.reg_ren <= 1'b0;
      apb.apb_err <= 1'b0;
      tx_wen      <= 1'b0;
      rx_ren      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      apb.reg_wen <= tx_acc;
      apb.reg_ren <= rx_acc;
      apb.apb_err <= tx_rej | rx_rej;
      tx_wen      <= (state_nxt == TX_PUSH);
      rx_ren      <= (state_nxt == RX_POP);
      busy        <= (state_nxt != IDLE);
    end
  end

  // In SETTLE, last_rx tells whether a pop just completed.
  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_pend  <= 1'b0;
      rx_valid <= 1'b0;
      last_rx  <= 1'b1;
    end else begin
      if (tx_acc)
        tx_pend <= 1'b1;
      else if (state == TX_PUSH)
        tx_pend <= 1'b0;

      if (rx_acc)
        rx_valid <= 1'b0;
      else if (state == SETTLE && last_rx)
        rx_valid <= 1'b1;

      if (state == TX_PUSH)
        last_rx <= 1'b0;
      else if (state == RX_POP)
        last_rx <= 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_chan  <= 1'b0;
      rx_seq   <= 1'b0;
      pop_chan <= 1'b0;
      rx_chan  <= 1'b0;
    end else begin
      if (!stereo)
        tx_chan <= 1'b0;
      else if (state == TX_PUSH)
        tx_chan <= ~tx_chan;

      if (!stereo)
        rx_seq <= 1'b0;
      else if (state == RX_POP)
        rx_seq <= ~rx_seq;

      if (state == RX_POP)
        pop_chan <= rx_seq;

      if (state == SETTLE && last_rx)
        rx_chan <= pop_chan;
    end
  end

`ifdef I2S_SCHED_STATS_EN
  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_drop_cnt  <= '0;
      rx_under_cnt <= '0;
    end else begin
      if (tx_rej && tx_drop_cnt != {CNT_W{1'b1}})
        tx_drop_cnt <= tx_drop_cnt + 1'b1;
      if (rx_rej && rx_under_cnt != {CNT_W{1'b1}})
        rx_under_cnt <= rx_under_cnt + 1'b1;
    end
  end
`else
  assign tx_drop_cnt  = '0;
  assign rx_under_cnt = '0;
`endif

endmodule
